// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game sequencer.
package snake_pkg;

    // FSM states; the encoding is visible on the state output port.
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_READY = 3'd1,
        ST_PLAY  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_HEAD  = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    // One-hot directions, bit order {down, up, right, left}.
    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_LEFT  = 4'b0001;
    localparam logic [3:0] DIR_RIGHT = 4'b0010;
    localparam logic [3:0] DIR_UP    = 4'b0100;
    localparam logic [3:0] DIR_DOWN  = 4'b1000;

    // Default geometry of the playfield and the snake at start.
    localparam int DEF_MAX_LEN   = 64;
    localparam int DEF_COORD_W   = 10;
    localparam int DEF_STEP      = 5;
    localparam int DEF_START_X   = 100;
    localparam int DEF_START_Y   = 100;
    localparam int DEF_START_LEN = 4;
    localparam int DEF_PARK_X    = 700;
    localparam int DEF_PARK_Y    = 500;

    // True when 'req' points straight back along 'cur'.
    function automatic logic is_reverse(input logic [3:0] req, input logic [3:0] cur);
        return (req == DIR_LEFT  && cur == DIR_RIGHT) ||
               (req == DIR_RIGHT && cur == DIR_LEFT)  ||
               (req == DIR_UP    && cur == DIR_DOWN)  ||
               (req == DIR_DOWN  && cur == DIR_UP);
    endfunction

    // Reduce a multi-hot request to one direction: left > right > up > down.
    function automatic logic [3:0] pick_dir(input logic [3:0] req);
        if (req[0])      return DIR_LEFT;
        else if (req[1]) return DIR_RIGHT;
        else if (req[2]) return DIR_UP;
        else if (req[3]) return DIR_DOWN;
        return DIR_NONE;
    endfunction

endpackage

// File: rtl/snake_seg_ram.sv
// Segment coordinate RAM: DEPTH entries of {x, y}, single port, registered read.
module snake_seg_ram #(
    parameter int DEPTH   = 64,
    parameter int COORD_W = 10,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic [ADDR_W-1:0]  addr,
    input  logic               we,
    input  logic [COORD_W-1:0] wx,
    input  logic [COORD_W-1:0] wy,
    output logic [COORD_W-1:0] rx,
    output logic [COORD_W-1:0] ry
);

    logic [2*COORD_W-1:0] mem [DEPTH];
    logic [2*COORD_W-1:0] rdata;

    // Write on we, read the addressed entry one cycle later (old data on a write).
    // NOTE: the array is deliberately not reset; the INIT sweep fills every entry, and a reset would turn the RAM into flops.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= {wx, wy};
        end
        rdata <= mem[addr];
    end

    assign rx = rdata[2*COORD_W-1:COORD_W];
    assign ry = rdata[COORD_W-1:0];

endmodule

// File: rtl/snake_seq_ctrl.sv
// Snake game sequencer: RAM init sweep, direction handling, serial body shift
// with self-collision check, and game status for the pixel/score logic.
module snake_seq_ctrl
    import snake_pkg::*;
#(
    parameter int MAX_LEN   = DEF_MAX_LEN,
    parameter int COORD_W   = DEF_COORD_W,
    parameter int STEP      = DEF_STEP,
    parameter int START_X   = DEF_START_X,
    parameter int START_Y   = DEF_START_Y,
    parameter int START_LEN = DEF_START_LEN,
    parameter int PARK_X    = DEF_PARK_X,
    parameter int PARK_Y    = DEF_PARK_Y,
    parameter int ADDR_W    = $clog2(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               pause,
    input  logic               tick,
    input  logic [3:0]         dir_req,
    input  logic               grow,
    input  logic               hit_border,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [COORD_W-1:0] mem_wx,
    output logic [COORD_W-1:0] mem_wy,
    input  logic [COORD_W-1:0] mem_rx,
    input  logic [COORD_W-1:0] mem_ry,
    output logic [COORD_W-1:0] head_x,
    output logic [COORD_W-1:0] head_y,
    output logic [ADDR_W:0]    length,
    output logic [3:0]         dir,
    output logic [2:0]         state,
    output logic               game_over,
    output logic               move_done,
    output logic               tick_drop
);

    localparam logic [ADDR_W:0]    MAX_LEN_L   = (ADDR_W+1)'(MAX_LEN);
    localparam logic [ADDR_W:0]    START_LEN_L = (ADDR_W+1)'(START_LEN);
    localparam logic [ADDR_W-1:0]  LAST_IDX    = ADDR_W'(MAX_LEN - 1);
    localparam logic [COORD_W-1:0] STEP_C      = COORD_W'(STEP);
    localparam logic [COORD_W-1:0] START_X_C   = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] START_Y_C   = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0] PARK_X_C    = COORD_W'(PARK_X);
    localparam logic [COORD_W-1:0] PARK_Y_C    = COORD_W'(PARK_Y);

    state_t             state_q;
    logic [ADDR_W-1:0]  idx;        // INIT sweep pointer / SHIFT destination entry
    logic               rd_phase;   // SHIFT: 1 = read cycle, 0 = write cycle
    logic [COORD_W-1:0] nxt_x, nxt_y;
    logic               self_hit;
    logic               grow_pend;
    logic [COORD_W-1:0] step_x, step_y;
    logic [ADDR_W:0]    grown_len;
    logic [3:0]         req_dir;
    logic               rx_match;

    assign state    = state_q;
    assign req_dir  = pick_dir(dir_req);
    assign rx_match = (mem_rx == nxt_x) && (mem_ry == nxt_y);

    // Candidate head one step along the current direction, plus length after a pending grow.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        step_x    = head_x;
        step_y    = head_y;
        grown_len = length;
        case (dir)
            DIR_LEFT:  step_x = head_x - STEP_C;
            DIR_RIGHT: step_x = head_x + STEP_C;
            DIR_UP:    step_y = head_y - STEP_C;
            DIR_DOWN:  step_y = head_y + STEP_C;
            default:   ;
        endcase
        if ((grow_pend || grow) && length < MAX_LEN_L) begin
            grown_len = length + 1'b1;
        end
    end

    // RAM port decode from the registered state; writes are suppressed while held in reset or not running.
    always_comb begin
        mem_addr = idx;
        mem_we   = 1'b0;
        mem_wx   = PARK_X_C;
        mem_wy   = PARK_Y_C;
        case (state_q)
            ST_INIT: begin
                mem_we = 1'b1;
                if (idx == '0) begin
                    mem_wx = START_X_C;
                    mem_wy = START_Y_C;
                end
            end
            ST_SHIFT: begin
                if (rd_phase) begin
                    mem_addr = idx - 1'b1;
                end else begin
                    mem_we = 1'b1;
                    mem_wx = mem_rx;
                    mem_wy = mem_ry;
                end
            end
            ST_HEAD: begin
                mem_addr = '0;
                mem_we   = 1'b1;
                mem_wx   = nxt_x;
                mem_wy   = nxt_y;
            end
            default: ;
        endcase
        if (reset || !run) begin
            mem_we = 1'b0;
        end
    end

    // Game FSM with registered status outputs and one-cycle pulses.
    // NOTE: non-blocking assignments throughout; a later assignment in this block overrides an earlier default on the same edge.
    always_ff @(posedge clk) begin
        move_done <= 1'b0;
        tick_drop <= 1'b0;
        if (reset || !run) begin
            state_q   <= ST_INIT;
            idx       <= '0;
            rd_phase  <= 1'b1;
            dir       <= DIR_NONE;
            length    <= START_LEN_L;
            head_x    <= START_X_C;
            head_y    <= START_Y_C;
            nxt_x     <= START_X_C;
            nxt_y     <= START_Y_C;
            game_over <= 1'b0;
            grow_pend <= 1'b0;
            self_hit  <= 1'b0;
        end else begin
            grow_pend <= grow_pend | grow;
            tick_drop <= tick && (state_q == ST_SHIFT || state_q == ST_HEAD);
            case (state_q)
                ST_INIT: begin
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state_q <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (req_dir != DIR_NONE) begin
                        dir     <= req_dir;
                        state_q <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (hit_border) begin
                        state_q   <= ST_OVER;
                        game_over <= 1'b1;
                        dir       <= DIR_NONE;
                    end else begin
                        if (req_dir != DIR_NONE && !is_reverse(req_dir, dir)) begin
                            dir <= req_dir;
                        end
                        if (tick && !pause) begin
                            nxt_x     <= step_x;
                            nxt_y     <= step_y;
                            length    <= grown_len;
                            grow_pend <= 1'b0;
                            idx       <= ADDR_W'(grown_len - 1'b1);
                            rd_phase  <= 1'b1;
                            self_hit  <= 1'b0;
                            state_q   <= (grown_len > 1) ? ST_SHIFT : ST_HEAD;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (rd_phase) begin
                        rd_phase <= 1'b0;
                    end else begin
                        rd_phase <= 1'b1;
                        idx      <= idx - 1'b1;
                        if (rx_match) begin
                            self_hit <= 1'b1;
                        end
                        if (idx == ADDR_W'(1)) begin
                            state_q <= ST_HEAD;
                        end
                    end
                end
                ST_HEAD: begin
                    head_x <= nxt_x;
                    head_y <= nxt_y;
                    if (self_hit) begin
                        state_q   <= ST_OVER;
                        game_over <= 1'b1;
                        dir       <= DIR_NONE;
                    end else begin
                        move_done <= 1'b1;
                        state_q   <= ST_PLAY;
                    end
                end
                ST_OVER: begin
                    game_over <= 1'b1;
                    dir       <= DIR_NONE;
                end
                default: begin
                    state_q <= ST_INIT;
                    idx     <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/snake_seq_ctrl.md
Name: snake_seq_ctrl

Overview:
Game sequencer for the snake datapath. It owns the single-port segment coordinate RAM (MAX_LEN entries of X/Y) and runs the game FSM: init, wait for first direction, play, pause, game over. Each accepted move tick shifts the body serially through the RAM, writes the new head and checks for self-collision. It replaces the combinational for-loop shift and gives the pixel/score logic a stable length, head and status.

Parameters:
MAX_LEN, 64, segment RAM depth; length saturates here
COORD_W, 10, coordinate width
STEP, 5, pixels moved per tick
START_X, 100, head X after init
START_Y, 100, head Y after init
START_LEN, 4, length after init
PARK_X, 700, X written to unused entries (off-screen)
PARK_Y, 500, Y written to unused entries (off-screen)

Ports:
clk  in  1  system clock (clk_25M domain)
reset  in  1  synchronous, active-high reset
run  in  1  game enable (SW[0]); low forces re-init
pause  in  1  freeze moves (SW[1])
tick  in  1  one-cycle move strobe (refresh, already synchronised to clk)
dir_req  in  4  one-hot request {down,up,right,left} = bits {3,2,1,0}
grow  in  1  one-cycle eat pulse
hit_border  in  1  head-on-border flag from pixel logic
mem_addr  out  log2(MAX_LEN)  RAM address
mem_we  out  1  RAM write enable
mem_wx, mem_wy  out  COORD_W each  write data
mem_rx, mem_ry  in  COORD_W each  read data, valid 1 cycle after address
head_x, head_y  out  COORD_W each  registered head position
length  out  log2(MAX_LEN)+1  current segment count
dir  out  4  current direction, 0 = not yet moving
state  out  3  FSM state encoding
game_over  out  1  high in OVER
move_done  out  1  one-cycle pulse when a move completes
tick_drop  out  1  one-cycle pulse when a tick arrives while a move is in progress

Behaviour:
- Reset or run=0: enter INIT with idx=0. Outputs cleared: mem_we=0, dir=0, length=START_LEN, head=START, game_over=0, pulses=0, grow_pend=0. run=0 aborts any state on the next cycle.
- INIT: one write per cycle. Entry 0 gets START; entries 1..MAX_LEN-1 get PARK. Takes MAX_LEN cycles, then READY.
- READY: the first nonzero dir_req is latched into dir and moves to PLAY. Ticks are ignored.
- PLAY: dir_req updates dir unless it is the reverse of dir (left/right, up/down); the reverse request is ignored. When several bits are set, priority is left>right>up>down. hit_border=1 moves to OVER. tick with pause=0 starts a move; tick with pause=1 is ignored.
- Move start (same cycle as tick): compute nxt_head = head ± STEP on the axis of dir, wrapping modulo 2^COORD_W. If grow_pend=1 and length<MAX_LEN, then length+=1; grow_pend is cleared either way. Set i=length-1 (new length) and go to SHIFT.
- SHIFT: 2 cycles per segment. Read cycle: mem_addr=i-1. Write cycle: mem_addr=i, mem_we=1, data=mem_rx/ry. In the write cycle the read value is compared with nxt_head; a match sets self_hit. Then i-=1. When i reaches 0, go to HEAD.
- HEAD: write nxt_head to addr 0 and update head_x/y. If self_hit, go to OVER; else pulse move_done and return to PLAY. Move latency = 2*(length-1)+2 cycles from tick (inclusive) to move_done.
- grow at any time is OR'd into grow_pend (sticky until consumed); two grows before one move count once.
- tick outside PLAY or while a move is in progress: ignored; tick_drop pulses only if a move is in progress.
- OVER: game_over=1, dir=0, RAM frozen; leave only via run=0 or reset.
- mem_we is 0 in every state except INIT, SHIFT write cycles and HEAD.

Decomposition:
- Package snake_pkg: state enum (INIT, READY, PLAY, SHIFT, HEAD, OVER), direction one-hot constants, reverse-check function, default coordinate constants.
- One natural sub-module, snake_seg_ram: MAX_LEN x 2*COORD_W single-port RAM with 1-cycle registered read, instantiated beside the controller so pixel logic can later use a second port.

Test Plan:
- Reset, run=1 -> MAX_LEN writes: addr0=(100,100), addr1..63=(700,500); state READY after 64 cycles; length=4.
- READY, dir_req=right, tick, length=4 -> move_done exactly 8 cycles after tick; head=(105,100); entries 1..3 = old 0..2.
- PLAY dir=right, dir_req=left -> dir stays right. dir_req=up, then tick -> head=(105,95).
- grow pulsed twice, then tick at length 4 -> length=5; entry 4 = old entry 3; shift takes 10 cycles.
- Length 5, path forms a loop onto body (up, left, down at STEP spacing) -> self_hit; OVER after HEAD; game_over=1; further ticks do not write.
- Mid-SHIFT: pulse tick -> tick_drop=1. Drop run -> INIT next cycle, mem_we pattern restarts at addr0. hit_border in PLAY -> OVER next cycle.
